// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty flag, memory read port and a
// 2-entry output skid buffer. Optional macro RD_LEVEL_EN adds the registered rlevel output.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR       = 6
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR:0]         rq2_wptr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR-1:0]       raddr,
    output logic                  rclken,
    output logic [ADDR:0]         rptr,
    output logic                  rempty,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
`ifdef RD_LEVEL_EN
    ,
    output logic [ADDR:0]         rlevel
`endif
);

    // Stream handshake: a word transfers on every rising edge where dout_valid and
    // dout_ready are both high; dout_valid never depends on dout_ready and dout holds
    // steady while the consumer stalls.

    logic [ADDR:0]         rbin_q, rbin_d;
    logic [ADDR:0]         rptr_q, rptr_d;
    logic                  rempty_q, rempty_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_count_q, buf_count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic                  pop;
    logic [2:0]            occupancy;
    logic [1:0]            count_after_pop;

    assign pop        = (buf_count_q != 2'd0) && dout_ready;
    assign dout       = buf0_q;
    assign dout_valid = (buf_count_q != 2'd0);
    assign raddr      = rbin_q[ADDR-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;

    // Words already owned by the read side after this cycle's pop; issuing only below 2
    // guarantees a free buffer slot for every word that comes back from memory.
    assign occupancy       = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign count_after_pop = buf_count_q - {1'b0, pop};

    always_comb begin
        rclken     = !rempty_q && (occupancy < 3'd2);
        rbin_d     = rbin_q + {{ADDR{1'b0}}, rclken};
        rptr_d     = (rbin_d >> 1) ^ rbin_d;
        rempty_d   = (rptr_d == rq2_wptr);
        inflight_d = rclken;
    end

    // Head is always buf0: a pop shifts buf1 forward, then the returning word lands in
    // the first free slot behind whatever remains.
    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        buf_count_d = count_after_pop + {1'b0, inflight_q};
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (count_after_pop == 2'd0) begin
                buf0_d = rdata;
            end else begin
                buf1_d = rdata;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q      <= '0;
            rptr_q      <= '0;
            rempty_q    <= 1'b1;
            inflight_q  <= 1'b0;
            buf_count_q <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_q      <= rptr_d;
            rempty_q    <= rempty_d;
            inflight_q  <= inflight_d;
            buf_count_q <= buf_count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

`ifdef RD_LEVEL_EN
    logic [ADDR:0] wbin;
    logic [ADDR:0] rlevel_q, rlevel_d;

    always_comb begin
        wbin[ADDR] = rq2_wptr[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
        rlevel_d = wbin - rbin_d;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_q <= '0;
        end else begin
            rlevel_q <= rlevel_d;
        end
    end

    assign rlevel = rlevel_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural memory, scoreboard queue of written words, vector
// table of drain scenarios plus hand sequences for reset, latency and rlevel.
module tb_fifo_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          rclk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rrst_n = 1'b1;
    logic [AW:0]   rq2_wptr = '0;
    logic [DW-1:0] rdata = '0;
    logic [AW-1:0] raddr;
    logic          rclken;
    logic [AW:0]   rptr;
    logic          rempty;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
`ifdef RD_LEVEL_EN
    logic [AW:0]   rlevel;
`endif

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR(AW)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rdata(rdata),
        .raddr(raddr), .rclken(rclken), .rptr(rptr), .rempty(rempty),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef RD_LEVEL_EN
        , .rlevel(rlevel)
`endif
    );

    // clock / reset
    always begin
        #5;
        if (clk_en) rclk = ~rclk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // behavioural memory with registered read
    logic [DW-1:0] mem [64];
    always @(posedge rclk) if (rclken) rdata <= mem[raddr];

    // scoreboard and monitor
    logic [DW-1:0] exp_q[$];
    logic [AW:0]   wbin = '0;
    int            cyc = 0;
    int            out_cnt = 0;
    logic [AW-1:0] exp_raddr = '0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_dout = '0;
    bit            mon_pop;
    int            first_pop = -1;
    int            last_pop = -1;
    int            pop_cnt = 0;

    always @(negedge rclk) begin
        cyc++;
        if (!rrst_n) begin
            out_cnt    = 0;
            exp_raddr  = '0;
            prev_stall = 0;
        end else begin
            mon_pop = dout_valid && dout_ready;
            if (rclken) begin
                check("issue_while_empty", {31'd0, rempty}, 32'd0);
                check("raddr_seq", {26'd0, raddr}, {26'd0, exp_raddr});
                exp_raddr = exp_raddr + 1'b1;
            end
            if (mon_pop) begin
                check("pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("dout_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
            if (prev_stall) check("dout_hold", {24'd0, dout}, {24'd0, prev_dout});
            out_cnt = out_cnt + int'(rclken) - int'(mon_pop);
            check("outstanding_le_2", {31'd0, out_cnt <= 2}, 32'd1);
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_words(input int n, input bit rnd);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DW'($urandom_range(0, 255)) : DW'(wbin);
            mem[wbin[AW-1:0]] = d;
            exp_q.push_back(d);
            wbin = wbin + 1'b1;
        end
        rq2_wptr = wbin ^ (wbin >> 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rempty"}, {31'd0, rempty}, 32'd1);
        check({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_rclken"}, {31'd0, rclken}, 32'd0);
        check({tag, "_rptr"}, {25'd0, rptr}, 32'd0);
        check({tag, "_raddr"}, {26'd0, raddr}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        wbin       = '0;
        rq2_wptr   = '0;
        dout_ready = 1'b0;
        @(posedge rclk);
        #3;
        rrst_n = 1'b1;
        step();
    endtask

    task automatic drain(input logic [3:0] pat);
        int c;
        for (c = 0; c < 2000 && exp_q.size() != 0; c++) begin
            dout_ready = pat[c % 4];
            step();
        end
        check("drain_done", exp_q.size(), 32'd0);
        dout_ready = 1'b0;
        repeat (3) step();
    endtask

    typedef struct {
        bit         rst;
        int         nwords;
        bit         rnd;
        logic [3:0] pat;
        logic [6:0] exp_rptr;
        logic [5:0] exp_raddr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{rst: 0, nwords: 64, rnd: 0, pat: 4'b1111, exp_rptr: 7'b1100000, exp_raddr: 6'd0};
        vecs[1] = '{rst: 1, nwords: 64, rnd: 0, pat: 4'b1001, exp_rptr: 7'b1100000, exp_raddr: 6'd0};
        vecs[2] = '{rst: 0, nwords: 10, rnd: 0, pat: 4'b1111, exp_rptr: 7'b1101111, exp_raddr: 6'd10};
        vecs[3] = '{rst: 0, nwords: 60, rnd: 1, pat: 4'b0101, exp_rptr: 7'b0000101, exp_raddr: 6'd6};

        // asynchronous reset with no clock running
        #3;
        rrst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        clk_en = 1'b1;
        repeat (3) @(posedge rclk);
        #3;
        rrst_n = 1'b1;
        step();

        // single word latency: E0 is the edge just before rq2_wptr changes
        mem[0] = 8'hA5;
        exp_q.push_back(8'hA5);
        wbin = 7'd1;
        rq2_wptr = 7'd1;
        step();
        check("e1_rempty", {31'd0, rempty}, 32'd0);
        check("e1_rclken", {31'd0, rclken}, 32'd1);
        step();
        check("e2_rclken", {31'd0, rclken}, 32'd0);
        check("e2_rempty", {31'd0, rempty}, 32'd1);
        check("e2_rptr", {25'd0, rptr}, 32'd1);
        check("e2_dout_valid", {31'd0, dout_valid}, 32'd0);
        step();
        check("e3_dout_valid", {31'd0, dout_valid}, 32'd1);
        check("e3_dout", {24'd0, dout}, 32'hA5);
        step();
        check("e3_hold_valid", {31'd0, dout_valid}, 32'd1);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        step();
        check("single_popped", exp_q.size(), 32'd0);
        check("single_dout_valid", {31'd0, dout_valid}, 32'd0);

        // reset mid-operation
        do_reset("pre_midop");
        write_words(20, 1);
        dout_ready = 1'b1;
        repeat (8) step();
        do_reset("midop_reset");
        check("midop_after_valid", {31'd0, dout_valid}, 32'd0);
        check("midop_after_rempty", {31'd0, rempty}, 32'd1);

        // vector table
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].rst) do_reset($sformatf("vec%0d_reset", v));
            first_pop = -1;
            last_pop  = -1;
            pop_cnt   = 0;
            write_words(vecs[v].nwords, vecs[v].rnd);
            drain(vecs[v].pat);
            check($sformatf("vec%0d_pop_cnt", v), pop_cnt, vecs[v].nwords);
            if (vecs[v].pat == 4'b1111)
                check($sformatf("vec%0d_no_gaps", v), last_pop - first_pop + 1, vecs[v].nwords);
            check($sformatf("vec%0d_rptr", v), {25'd0, rptr}, {25'd0, vecs[v].exp_rptr});
            check($sformatf("vec%0d_raddr", v), {26'd0, raddr}, {26'd0, vecs[v].exp_raddr});
            check($sformatf("vec%0d_rempty", v), {31'd0, rempty}, 32'd1);
            check($sformatf("vec%0d_dout_valid", v), {31'd0, dout_valid}, 32'd0);
        end

`ifdef RD_LEVEL_EN
        do_reset("level_reset");
        check("rlevel_reset", {25'd0, rlevel}, 32'd0);
        write_words(5, 1);
        step();
        check("rlevel_e1", {25'd0, rlevel}, 32'd5);
        repeat (8) step();
        check("rlevel_hold", {25'd0, rlevel}, 32'd3);
        drain(4'b1111);
        check("rlevel_drained", {25'd0, rlevel}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the asynchronous FIFO, in the rclk domain. It owns the read pointer and empty detection, and drives the memory read port (raddr, rclken). It absorbs the memory's 1-cycle registered read latency. It presents popped words to the consumer on a valid/ready stream. It is the reader counterpart to the write-side pointer logic, and takes the write pointer already synchronized into rclk.

Parameters:
DATA_WIDTH, 8, width of each FIFO word.
ADDR, 6, memory address width; depth = 2**ADDR; pointers are ADDR+1 bits.

Ports:
rclk  input  1  read clock; all state on rising edge.
rrst_n  input  1  asynchronous active-low reset.
rq2_wptr  input  ADDR+1  Gray write pointer, already 2-flop synchronized into rclk.
rdata  input  DATA_WIDTH  memory read data; valid the cycle after rclken.
raddr  output  ADDR  memory read address.
rclken  output  1  memory read enable; one pop from memory per asserted cycle.
rptr  output  ADDR+1  registered Gray read pointer, sent to the write domain.
rempty  output  1  memory holds no unread words.
dout  output  DATA_WIDTH  stream data to consumer.
dout_valid  output  1  dout holds a valid word.
dout_ready  input  1  consumer accepts dout this cycle.

Behaviour:
- Reset (async assert, sync release): rbin=0, rptr=0, rempty=1, rclken=0, inflight=0, buf_count=0, dout_valid=0, dout=0.
- Pointers:
  - rbin is the (ADDR+1)-bit binary read pointer; raddr = rbin[ADDR-1:0].
  - rbin_next = rbin + rclken, wrapping modulo 2**(ADDR+1).
  - rgray_next = (rbin_next>>1) ^ rbin_next.
  - rptr <= rgray_next and rempty <= (rgray_next == rq2_wptr), both registered.
- Output buffer: 2-entry in-order skid buffer; buf_count ranges 0..2.
  - pop = dout_valid & dout_ready.
  - dout = head entry; dout_valid = (buf_count != 0).
  - dout is held stable while dout_valid=1 and dout_ready=0.
- inflight: register set to rclken each cycle, marking rdata valid in the following cycle.
- Issue rule, combinational: rclken = !rempty && (buf_count + inflight - pop) < 2. The buffer can therefore never overflow.
- Capture: when inflight=1, rdata is written into the buffer tail that cycle. The same-cycle pop and capture is legal and buf_count is unchanged.
- Latency: rq2_wptr goes non-empty after edge E0.
  - rempty falls at E1.
  - rclken is high during the cycle after E1, and memory is read at E2.
  - The word is captured at E3; dout_valid is high after E3.
- Throughput: 1 word/cycle sustained when dout_ready is held high.
- Boundaries:
  - Empty: rclken is never asserted while rempty=1.
  - Last word: rempty rises on the same edge rbin advances past the last written entry.
  - Wrap-around: the Gray MSB toggles each pass. Full (from the writer's view) is not an error here.
  - Backpressure: issue stops once buf_count + inflight would reach 2. Nothing is lost.
- Reset mid-operation: the buffer and in-flight word are discarded and the pointers are cleared. The write domain must be reset concurrently.

Optional Feature:
RD_LEVEL_EN.
- Defined: adds output rlevel [ADDR:0], registered, reset 0.
  - rlevel = gray2bin(rq2_wptr) - rbin_next, modulo 2**(ADDR+1).
  - It counts unread words in memory, excluding the buffer and in-flight word, and may lag the writer by synchronizer delay.
- Undefined: no rlevel port and no gray-to-binary logic.

Test Plan:
- Assert rrst_n=0 mid-cycle with no clock running. Required: rempty=1, dout_valid=0, rclken=0, rptr=0, raddr=0 asynchronously.
- Single word 0xA5 at address 0, rq2_wptr 0->1 after E0. Required: rclken high for one cycle after E1; dout=0xA5 and dout_valid=1 after E3; rempty stays 1 from E2; rptr=1.
- 64 words 0..63 pre-written, rq2_wptr=7'b1100000 (Gray 64), dout_ready=1. Required: 64 consecutive dout values 0..63 with no gaps; rempty=1 afterwards; rptr=7'b1100000.
- Same 64 words with dout_ready toggling 1,0,0,1 repeated. Required: in-order output, no duplicates or drops; buf_count + inflight never exceeds 2; dout stable while stalled.
- Wrap-around: drain 64, then 10 more words written at addresses 0..9 (rq2_wptr=Gray 74). Required: raddr wraps 63->0; the rptr MSB pattern matches Gray 74 when drained.
- RD_LEVEL_EN defined: 5 words pending, no reads (dout_ready=0 before issue starts). Required: rlevel steps from 5 to 3 as two words enter buffer/inflight, then holds at 3.
